// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
// Other regfile files import this package for their parameter defaults.
package regfile_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int NREGS_DEF  = 32;
  localparam int NREAD_DEF  = 2;
  localparam int NWRITE_DEF = 1;
  localparam int AW_DEF     = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_if.sv
// Read, write and alloc bundle between issue/writeback (master) and the register file (slave).
// Ports are flat vectors: read port r lives at [r*AW +: AW] and [r*XLEN +: XLEN].
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NREAD  = NREAD_DEF,
  parameter int NWRITE = NWRITE_DEF
);
  localparam int AW = $clog2(NREGS);

  logic [NREAD*AW-1:0]    raddr;
  logic [NREAD*XLEN-1:0]  rdata;
  logic [NREAD-1:0]       rbusy;
  logic [NWRITE-1:0]      we;
  logic [NWRITE*AW-1:0]   waddr;
  logic [NWRITE*XLEN-1:0] wdata;
  logic                   alloc_valid;
  logic [AW-1:0]          alloc_addr;

  modport master (
    output raddr, we, waddr, wdata, alloc_valid, alloc_addr,
    input  rdata, rbusy
  );

  modport slave (
    input  raddr, we, waddr, wdata, alloc_valid, alloc_addr,
    output rdata, rbusy
  );

endinterface

// File: rtl/regfile_wsel.sv
// Write-port selector: reports whether any enabled write port targets addr and returns its data.
// Purely combinational; the highest-index matching port wins, no backpressure.
module regfile_wsel
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int AW     = AW_DEF,
  parameter int NWRITE = NWRITE_DEF
) (
  input  logic [AW-1:0]          addr,
  input  logic [NWRITE-1:0]      we,
  input  logic [NWRITE*AW-1:0]   waddr,
  input  logic [NWRITE*XLEN-1:0] wdata,
  output logic                   hit,
  output logic [XLEN-1:0]        data
);

  // Ascending scan so a later (higher-index) port overrides earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int w = 0; w < NWRITE; w++) begin
      if (we[w] && (waddr[w*AW +: AW] == addr)) begin
        hit  = 1'b1;
        data = wdata[w*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// N-read / M-write register file with per-register busy scoreboard; reads are zero-latency.
// Optional write-to-read forwarding under REGFILE_BYPASS_EN; no backpressure, all writes/allocs accepted.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NREAD    = NREAD_DEF,
  parameter int NWRITE   = NWRITE_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic      clk,
  input  logic      reset,
  regfile_if.slave  rf
);

  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           busy_q, busy_d;

  logic                       wr_hit [NREGS];
  logic [XLEN-1:0]            wr_dat [NREGS];

  logic [NREAD-1:0][XLEN-1:0] rdata_a;
  logic [NREAD-1:0]           rbusy_a;

  for (genvar i = 0; i < NREGS; i++) begin : g_wsel
    regfile_wsel #(
      .XLEN   (XLEN),
      .AW     (AW),
      .NWRITE (NWRITE)
    ) u_wsel (
      .addr  (AW'(i)),
      .we    (rf.we),
      .waddr (rf.waddr),
      .wdata (rf.wdata),
      .hit   (wr_hit[i]),
      .data  (wr_dat[i])
    );
  end

`ifdef REGFILE_BYPASS_EN
  logic            byp_hit [NREAD];
  logic [XLEN-1:0] byp_dat [NREAD];

  for (genvar r = 0; r < NREAD; r++) begin : g_byp
    regfile_wsel #(
      .XLEN   (XLEN),
      .AW     (AW),
      .NWRITE (NWRITE)
    ) u_byp (
      .addr  (rf.raddr[r*AW +: AW]),
      .we    (rf.we),
      .waddr (rf.waddr),
      .wdata (rf.wdata),
      .hit   (byp_hit[r]),
      .data  (byp_dat[r])
    );
  end
`endif

  // Alloc is applied after the write clears so a same-cycle set wins.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int i = 0; i < NREGS; i++) begin
      if (wr_hit[i] && !(ZERO_REG != 0 && i == 0)) begin
        regs_d[i] = wr_dat[i];
        busy_d[i] = 1'b0;
      end
    end
    if (rf.alloc_valid && !(ZERO_REG != 0 && rf.alloc_addr == '0)) begin
      busy_d[rf.alloc_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    logic [AW-1:0] ra;
    ra      = '0;
    rdata_a = '0;
    rbusy_a = '0;
    for (int r = 0; r < NREAD; r++) begin
      ra         = rf.raddr[r*AW +: AW];
      rdata_a[r] = regs_q[ra];
      rbusy_a[r] = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
      if (byp_hit[r]) begin
        rdata_a[r] = byp_dat[r];
        rbusy_a[r] = rf.alloc_valid && (rf.alloc_addr == ra);
      end
`endif
      // Reset also masks forwarded data so outputs read 0 for the whole reset window.
      if (reset || (ZERO_REG != 0 && ra == '0)) begin
        rdata_a[r] = '0;
        rbusy_a[r] = 1'b0;
      end
    end
  end

  assign rf.rdata = rdata_a;
  assign rf.rbusy = rbusy_a;

endmodule
